decoder_kind_shift_unit: RTL and testbench
==========================================

Name: decoder_kind_shift_unit

Overview:
- Front-end decode slice that classifies a 32-bit instruction word into an instruction kind (e_kind) and extracts its shift descriptor (s_shift: operation plus 5-bit amount).
- Sits between instruction fetch and operand/ALU setup.
- Kind decode feeds shift decode internally.
- Both results are registered once and presented with a valid flag.

Parameters:
- None. All widths are fixed: instruction 32 bits, kind 4 bits, shift op 3 bits, shift amount 5 bits.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  instruction presented this cycle.
- instruction  input  32  instruction word.
- out_valid  output  1  kind/shift hold a decoded instruction.
- kind  output  4  e_kind of the registered instruction.
- shift  output  8  s_shift packed as {op[2:0], amount[4:0]}, op in bits 7:5.

Behaviour:
- e_kind encoding, decoded from instruction[31:28]:
  - 0x0 KIND_RRR
  - 0x1 KIND_RRI
  - 0x2 KIND_RI
  - 0x3 KIND_MEM
  - 0x4 KIND_BRANCH
  - 0x5–0xF KIND_INVALID, encoded 4'hF
- Shift op encoding:
  - SHIFT_SHL 3'd0
  - SHIFT_SHR 3'd1 (logical)
  - SHIFT_SAR 3'd2 (arithmetic)
  - SHIFT_ROR 3'd3
  - SHIFT_NONE 3'd4
  - SHIFT_INVALID 3'd7
- Shift decode for KIND_RRR and KIND_RRI:
  - op field = instruction[7:5]: 000 SHL, 001 SHR, 010 SAR, 011 ROR, 100–111 SHIFT_INVALID.
  - amount = instruction[4:0], passed through unchanged, including when op is SHIFT_INVALID.
- Shift decode for KIND_RI, KIND_MEM, KIND_BRANCH: shift = {SHIFT_NONE, 5'b0}.
- Shift decode for KIND_INVALID: shift = {SHIFT_INVALID, 5'b0}.
- Kind and shift decoding is purely combinational. Shift decode depends only on the decoded kind and instruction[7:0].
- Registering, per rising clk edge:
  - rst_n low: out_valid=0, kind=KIND_INVALID, shift={SHIFT_NONE,5'b0}. Reset has priority over in_valid.
  - rst_n high and in_valid=1: kind/shift load the decode of instruction; out_valid=1.
  - rst_n high and in_valid=0: out_valid=0; kind/shift hold their previous values.
- Latency: exactly 1 cycle from in_valid to out_valid; throughput one instruction per cycle, back-to-back.
- Reset asserted mid-stream: the next edge clears all outputs regardless of input; the first valid after rst_n deasserts appears one cycle later.
- instruction X/undriven while in_valid=0 must not affect registered outputs.
- No internal state beyond the output registers.

Test Plan:
- Reset: hold rst_n=0 two cycles with in_valid=1, instruction=0 -> out_valid=0, kind=4'hF, shift=8'h80.
- RRR zero: instruction=32'h0000_0000, in_valid=1 -> next cycle out_valid=1, kind=KIND_RRR, shift={SHIFT_SHL,5'b00000}=8'h00.
- RRR invalid op: instruction=32'h0FFF_FFFF -> kind=KIND_RRR, shift={SHIFT_INVALID,5'b11111}=8'hFF.
- Op sweep on RRI: instruction=32'h1000_0000 | (op<<5) | 5'd13 for op 0..7 back-to-back -> kind=KIND_RRI each cycle; shift ops SHL, SHR, SAR, ROR, then INVALID×4; amount=13 throughout; out_valid continuously 1.
- Non-shift and invalid kinds:
  - 32'h2000_00FF -> KIND_RI, 8'h80.
  - 32'h4000_001F -> KIND_BRANCH, 8'h80.
  - 32'h9000_0005 -> KIND_INVALID, 8'hE0.
- Hold and reset mid-stream: valid instruction, then in_valid=0 for three cycles -> out_valid=0 and kind/shift unchanged; then rst_n=0 for one edge -> reset values.

Source files
------------

// File: rtl/decoder_kind_shift_unit.sv
// Classifies an instruction word into its kind and shift descriptor, then registers
// both results with a valid flag.
module decoder_kind_shift_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] instruction,
  output logic        out_valid,
  output logic [3:0]  kind,
  output logic [7:0]  shift
);

  typedef enum logic [3:0] {
    KIND_RRR     = 4'h0,
    KIND_RRI     = 4'h1,
    KIND_RI      = 4'h2,
    KIND_MEM     = 4'h3,
    KIND_BRANCH  = 4'h4,
    KIND_INVALID = 4'hF
  } e_kind;

  typedef enum logic [2:0] {
    SHIFT_SHL     = 3'd0,
    SHIFT_SHR     = 3'd1,
    SHIFT_SAR     = 3'd2,
    SHIFT_ROR     = 3'd3,
    SHIFT_NONE    = 3'd4,
    SHIFT_INVALID = 3'd7
  } e_shift_op;

  typedef struct packed {
    e_shift_op  op;
    logic [4:0] amount;
  } s_shift;

  e_kind  kind_dec;
  s_shift shift_dec;

  always_comb begin
    case (instruction[31:28])
      4'h0:    kind_dec = KIND_RRR;
      4'h1:    kind_dec = KIND_RRI;
      4'h2:    kind_dec = KIND_RI;
      4'h3:    kind_dec = KIND_MEM;
      4'h4:    kind_dec = KIND_BRANCH;
      default: kind_dec = KIND_INVALID;
    endcase
  end

  // Amount passes through for register forms even when the op field is unsupported.
  always_comb begin
    shift_dec.op     = SHIFT_NONE;
    shift_dec.amount = 5'd0;
    case (kind_dec)
      KIND_RRR, KIND_RRI: begin
        shift_dec.amount = instruction[4:0];
        case (instruction[7:5])
          3'b000:  shift_dec.op = SHIFT_SHL;
          3'b001:  shift_dec.op = SHIFT_SHR;
          3'b010:  shift_dec.op = SHIFT_SAR;
          3'b011:  shift_dec.op = SHIFT_ROR;
          default: shift_dec.op = SHIFT_INVALID;
        endcase
      end
      KIND_INVALID: shift_dec.op = SHIFT_INVALID;
      default:      shift_dec.op = SHIFT_NONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      kind      <= KIND_INVALID;
      shift     <= {SHIFT_NONE, 5'd0};
    end else if (in_valid) begin
      out_valid <= 1'b1;
      kind      <= kind_dec;
      shift     <= shift_dec;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decoder_kind_shift_unit.sv
// Directed and randomized checks of decoder_kind_shift_unit against an arithmetic
// reference model of the decode rules and output registers.
module tb_decoder_kind_shift_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] instruction;
  logic        out_valid;
  logic [3:0]  kind;
  logic [7:0]  shift;

  int checks = 0;
  int errors = 0;

  logic       m_valid;
  logic [3:0] m_kind;
  logic [7:0] m_shift;

  decoder_kind_shift_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .instruction (instruction),
    .out_valid   (out_valid),
    .kind        (kind),
    .shift       (shift)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] ref_kind(input logic [31:0] i);
    int top = int'(i[31:28]);
    return (top <= 4) ? 4'(top) : 4'hF;
  endfunction

  function automatic logic [7:0] ref_shift(input logic [31:0] i);
    int top = int'(i[31:28]);
    int f   = int'(i[7:5]);
    int amt = int'(i[4:0]);
    if (top <= 1) return 8'((((f < 4) ? f : 7) * 32) + amt);
    else if (top <= 4) return 8'd128;
    else return 8'd224;
  endfunction

  // Drives one cycle of inputs, advances through the rising edge, updates the model,
  // and returns at the following falling edge where outputs are stable.
  task automatic apply(input logic r, input logic v, input logic [31:0] instr);
    rst_n       = r;
    in_valid    = v;
    instruction = instr;
    @(posedge clk);
    if (!r) begin
      m_valid = 1'b0;
      m_kind  = 4'hF;
      m_shift = 8'h80;
    end else if (v) begin
      m_valid = 1'b1;
      m_kind  = ref_kind(instr);
      m_shift = ref_shift(instr);
    end else begin
      m_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      apply(1'b0, 1'b1, 32'h0);
      checks++;
      if (out_valid !== 1'b0 || kind !== 4'hF || shift !== 8'h80) begin
        errors++;
        $display("FAIL reset cycle %0d: got valid=%0b kind=%0h shift=%0h, expected valid=0 kind=f shift=80",
                 c, out_valid, kind, shift);
      end
    end
  endtask

  task automatic test_rrr();
    apply(1'b1, 1'b1, 32'h0000_0000);
    checks++;
    if (out_valid !== 1'b1 || kind !== 4'h0 || shift !== 8'h00) begin
      errors++;
      $display("FAIL rrr_zero: got valid=%0b kind=%0h shift=%0h, expected valid=1 kind=0 shift=00",
               out_valid, kind, shift);
    end
    apply(1'b1, 1'b1, 32'h0FFF_FFFF);
    checks++;
    if (out_valid !== 1'b1 || kind !== 4'h0 || shift !== 8'hFF) begin
      errors++;
      $display("FAIL rrr_invalid_op: got valid=%0b kind=%0h shift=%0h, expected valid=1 kind=0 shift=ff",
               out_valid, kind, shift);
    end
  endtask

  task automatic test_op_sweep();
    for (int op = 0; op < 8; op++) begin
      logic [31:0] instr;
      logic [7:0]  exp_shift;
      instr     = 32'h1000_0000 | (32'(op) << 5) | 32'd13;
      exp_shift = 8'((((op < 4) ? op : 7) * 32) + 13);
      apply(1'b1, 1'b1, instr);
      checks++;
      if (out_valid !== 1'b1 || kind !== 4'h1 || shift !== exp_shift) begin
        errors++;
        $display("FAIL op_sweep op=%0d: got valid=%0b kind=%0h shift=%0h, expected valid=1 kind=1 shift=%0h",
                 op, out_valid, kind, shift, exp_shift);
      end
    end
  endtask

  task automatic test_kinds();
    logic [31:0] instrs [3] = '{32'h2000_00FF, 32'h4000_001F, 32'h9000_0005};
    logic [3:0]  kinds  [3] = '{4'h2, 4'h4, 4'hF};
    logic [7:0]  shifts [3] = '{8'h80, 8'h80, 8'hE0};
    for (int k = 0; k < 3; k++) begin
      apply(1'b1, 1'b1, instrs[k]);
      checks++;
      if (out_valid !== 1'b1 || kind !== kinds[k] || shift !== shifts[k]) begin
        errors++;
        $display("FAIL kinds %0h: got valid=%0b kind=%0h shift=%0h, expected valid=1 kind=%0h shift=%0h",
                 instrs[k], out_valid, kind, shift, kinds[k], shifts[k]);
      end
    end
  endtask

  task automatic test_hold_reset();
    apply(1'b1, 1'b1, 32'h1000_0065);
    checks++;
    if (out_valid !== 1'b1 || kind !== 4'h1 || shift !== 8'h65) begin
      errors++;
      $display("FAIL hold_load: got valid=%0b kind=%0h shift=%0h, expected valid=1 kind=1 shift=65",
               out_valid, kind, shift);
    end
    for (int c = 0; c < 3; c++) begin
      apply(1'b1, 1'b0, $urandom());
      checks++;
      if (out_valid !== 1'b0 || kind !== 4'h1 || shift !== 8'h65) begin
        errors++;
        $display("FAIL hold cycle %0d: got valid=%0b kind=%0h shift=%0h, expected valid=0 kind=1 shift=65",
                 c, out_valid, kind, shift);
      end
    end
    apply(1'b0, 1'b1, 32'h0000_0000);
    checks++;
    if (out_valid !== 1'b0 || kind !== 4'hF || shift !== 8'h80) begin
      errors++;
      $display("FAIL mid_reset: got valid=%0b kind=%0h shift=%0h, expected valid=0 kind=f shift=80",
               out_valid, kind, shift);
    end
    apply(1'b1, 1'b1, 32'h3000_0000);
    checks++;
    if (out_valid !== 1'b1 || kind !== 4'h3 || shift !== 8'h80) begin
      errors++;
      $display("FAIL after_reset: got valid=%0b kind=%0h shift=%0h, expected valid=1 kind=3 shift=80",
               out_valid, kind, shift);
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 20; c++) begin
      logic [31:0] instr;
      instr = {4'($urandom_range(0, 5)), 28'($urandom())};
      apply(1'b1, 1'b1, instr);
      checks++;
      if (out_valid !== 1'b1 || kind !== m_kind || shift !== m_shift) begin
        errors++;
        $display("FAIL back_to_back %0h: got valid=%0b kind=%0h shift=%0h, expected valid=1 kind=%0h shift=%0h",
                 instr, out_valid, kind, shift, m_kind, m_shift);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      logic        r;
      logic        v;
      logic [31:0] instr;
      r     = ($urandom_range(0, 19) != 0);
      v     = ($urandom_range(0, 3) != 0);
      instr = {4'($urandom_range(0, 15)), 28'($urandom())};
      apply(r, v, instr);
      checks++;
      if (out_valid !== m_valid || kind !== m_kind || shift !== m_shift) begin
        errors++;
        $display("FAIL random c=%0d instr=%0h: got valid=%0b kind=%0h shift=%0h, expected valid=%0b kind=%0h shift=%0h",
                 c, instr, out_valid, kind, shift, m_valid, m_kind, m_shift);
      end
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    instruction = 32'h0;
    m_valid     = 1'b0;
    m_kind      = 4'hF;
    m_shift     = 8'h80;
    test_reset();
    test_rrr();
    test_op_sweep();
    test_kinds();
    test_hold_reset();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
